// File: rtl/riscv_xc_regbank.sv
// ---------------------------------------------------------------------------
// riscv_xc_regbank
//
// Integer + XCrypto register bank for RI5CY-XCrypto. The number of read and
// write ports is set by parameters. The address MSB selects the bank:
//   addr[ADDR_WIDTH-1] = 0 : integer bank, index = addr[$clog2(INT_WORDS)-1:0]
//   addr[ADDR_WIDTH-1] = 1 : XC bank,      index = addr[$clog2(XC_WORDS)-1:0]
// Integer x0 is hardwired to zero, and writes to it are discarded.
//
// The XC bank can be cleared by a small sequencer (xc.init). When started, it
// zeroes CLR_PER_CYCLE words per cycle. While it runs (busy), XC reads return
// zero and all XC writes are discarded. When the last group has been cleared,
// done pulses for one cycle. The request is a level signal and is sampled
// only in IDLE. A request that is still held after done does not start a
// second clear; it must go low first.
//
// Optional feature (macro RF_WRITE_BYPASS_EN):
//   defined   : a read port forwards the wdata of a same-cycle write to the
//               same register. If several write ports match, the
//               highest-index enabled port wins. x0 still reads 0, and XC
//               reads still return 0 while busy.
//   undefined : reads show the register contents before the edge. New data
//               becomes visible in the cycle after the write.
//
// Ports
//   clk             in   clock
//   rst             in   asynchronous active-high reset
//   raddr_i         in   NUM_RPORTS packed read addresses, port 0 in LSBs
//   rdata_o         out  NUM_RPORTS packed read data (combinational)
//   waddr_i         in   NUM_WPORTS packed write addresses
//   wdata_i         in   NUM_WPORTS packed write data
//   we_i            in   per-port write enables, higher index has priority
//   xc_init_req_i   in   level request to clear the XC bank
//   xc_init_busy_o  out  clear sequence in progress
//   xc_init_done_o  out  one-cycle pulse after the last group is cleared
// ---------------------------------------------------------------------------
module riscv_xc_regbank #(
  parameter int DATA_WIDTH    = 32,
  parameter int INT_WORDS     = 32,
  parameter int XC_WORDS      = 16,
  parameter int NUM_RPORTS    = 3,
  parameter int NUM_WPORTS    = 2,
  parameter int CLR_PER_CYCLE = 4,
  parameter int ADDR_WIDTH    = $clog2(INT_WORDS) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
  input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WPORTS-1:0]            we_i,
  input  logic                             xc_init_req_i,
  output logic                             xc_init_busy_o,
  output logic                             xc_init_done_o
);

  // Clamp the index widths to at least 1 bit so that degenerate sizes
  // still elaborate.
  localparam int INT_AW = (INT_WORDS > 1) ? $clog2(INT_WORDS) : 1;
  localparam int XC_AW  = (XC_WORDS  > 1) ? $clog2(XC_WORDS)  : 1;

  // The clear pointer advances by one group each cycle. LAST_PTR is the
  // base index of the final group.
  localparam logic [XC_AW-1:0] CLR_STEP = XC_AW'(CLR_PER_CYCLE);
  localparam logic [XC_AW-1:0] LAST_PTR = XC_AW'(XC_WORDS - CLR_PER_CYCLE);

  // Clear sequencer states
  //   state      | meaning
  //   -----------+---------------------------------------------------------
  //   S_IDLE     | waiting for xc_init_req_i; the only state that samples it
  //   S_CLEAR    | zeroing one group of XC words per cycle; busy=1
  //   S_DONE     | done pulse cycle; busy=0
  //   S_WAIT_LOW | clear finished; wait for the request to drop
  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE,
    S_WAIT_LOW
  } state_e;

  state_e            state;
  logic [XC_AW-1:0]  clr_ptr;
  logic              busy_q;
  logic              done_q;

  logic [DATA_WIDTH-1:0] int_q [INT_WORDS];
  logic [DATA_WIDTH-1:0] xc_q  [XC_WORDS];

  // -------------------------------------------------------------------------
  // Write port decode
  // -------------------------------------------------------------------------
  logic [NUM_WPORTS-1:0] w_int_en;
  logic [NUM_WPORTS-1:0] w_xc_en;
  logic [INT_AW-1:0]     w_int_idx [NUM_WPORTS];
  logic [XC_AW-1:0]      w_xc_idx  [NUM_WPORTS];
  logic [DATA_WIDTH-1:0] w_data    [NUM_WPORTS];

  for (genvar p = 0; p < NUM_WPORTS; p++) begin : g_wdec
    logic [ADDR_WIDTH-1:0] wa;

    assign wa           = waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_int_idx[p] = wa[INT_AW-1:0];
    assign w_xc_idx[p]  = wa[XC_AW-1:0];
    assign w_data[p]    = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];

    // Writes to x0 are discarded here, so int_q[0] keeps its reset value of
    // zero. The x0 read path therefore needs no special case.
    assign w_int_en[p]  = we_i[p] & ~wa[ADDR_WIDTH-1] & (wa[INT_AW-1:0] != '0);

    // While the clear runs, the whole XC bank ignores writes. This includes
    // words that have already been cleared.
    assign w_xc_en[p]   = we_i[p] &  wa[ADDR_WIDTH-1] & ~busy_q;
  end

  // -------------------------------------------------------------------------
  // Integer bank
  // Ports are applied in ascending order, so for the same register the
  // highest-index port's non-blocking assignment is the one that lands.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INT_WORDS; i++) begin
        int_q[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (w_int_en[p]) begin
          int_q[w_int_idx[p]] <= w_data[p];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // XC bank and clear sequencer
  // Writes and the clear never conflict, because writes are gated off for the
  // whole time the sequencer is in S_CLEAR.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      clr_ptr <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < XC_WORDS; i++) begin
        xc_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (w_xc_en[p]) begin
          xc_q[w_xc_idx[p]] <= w_data[p];
        end
      end

      case (state)
        S_IDLE: begin
          if (xc_init_req_i) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            busy_q  <= 1'b1;
          end
        end

        S_CLEAR: begin
          for (int k = 0; k < CLR_PER_CYCLE; k++) begin
            xc_q[clr_ptr + XC_AW'(k)] <= '0;
          end
          if (clr_ptr == LAST_PTR) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + CLR_STEP;
          end
        end

        S_DONE: begin
          state <= S_WAIT_LOW;
        end

        S_WAIT_LOW: begin
          if (!xc_init_req_i) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign xc_init_busy_o = busy_q;
  assign xc_init_done_o = done_q;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  for (genvar r = 0; r < NUM_RPORTS; r++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  r_xc;
    logic [DATA_WIDTH-1:0] stored;
    logic [DATA_WIDTH-1:0] rd;

    assign ra   = raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
    assign r_xc = ra[ADDR_WIDTH-1];

    always_comb begin
      stored = '0;
      if (r_xc) begin
        if (!busy_q) begin
          stored = xc_q[ra[XC_AW-1:0]];
        end
      end else begin
        stored = int_q[ra[INT_AW-1:0]];
      end
    end

`ifdef RF_WRITE_BYPASS_EN
    // Forward a same-cycle write. The write enables already exclude x0 and
    // busy-time XC writes, so those reads still return 0. Scanning the ports
    // in ascending order makes the highest-index match win.
    always_comb begin
      rd = stored;
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (!r_xc && w_int_en[p] && (w_int_idx[p] == ra[INT_AW-1:0])) begin
          rd = w_data[p];
        end
        if (r_xc && w_xc_en[p] && (w_xc_idx[p] == ra[XC_AW-1:0])) begin
          rd = w_data[p];
        end
      end
    end
`else
    assign rd = stored;
`endif

    assign rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

endmodule

// File: tb/tb_riscv_xc_regbank.sv
module tb_riscv_xc_regbank;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 3;
  localparam int NW = 2;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NW-1:0]     we;
  logic              xc_init_req;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_v;

  logic [DW-1:0] int_m [32];
  logic [DW-1:0] xc_m  [16];

  riscv_xc_regbank dut (
    .clk            (clk),
    .rst            (rst),
    .raddr_i        (raddr),
    .rdata_o        (rdata),
    .waddr_i        (waddr),
    .wdata_i        (wdata),
    .we_i           (we),
    .xc_init_req_i  (xc_init_req),
    .xc_init_busy_o (busy),
    .xc_init_done_o (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] ia(input int i);
    return AW'(i) & 6'h1F;
  endfunction

  function automatic logic [AW-1:0] xa(input int i);
    return 6'h20 | (AW'(i) & 6'h1F);
  endfunction

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  task automatic set_w(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic en);
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    we[p] = en;
  endtask

  task automatic set_r(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    we = '0; waddr = '0; wdata = '0; raddr = '0; xc_init_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_r(0, ia(5));
    set_r(1, xa(3));
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    @(negedge clk);
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL reset_x5 got=%h exp=%h", rd(0), exp_v); end
    exp_v = sb.pop_front();
    n_cmp++; if (rd(1) !== exp_v) begin n_err++; $display("FAIL reset_xc3 got=%h exp=%h", rd(1), exp_v); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_write_priority;
    tick;
    set_w(0, ia(7), 32'hDEAD_BEEF, 1'b1);
    set_w(1, ia(7), 32'h1234_5678, 1'b1);
    set_r(0, ia(7));
`ifdef RF_WRITE_BYPASS_EN
    sb.push_back(32'h1234_5678);
`else
    sb.push_back(32'h0);
`endif
    @(negedge clk);
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL prio_same_cycle got=%h exp=%h", rd(0), exp_v); end
    sb.push_back(32'h1234_5678);
    tick;
    we = '0;
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL prio_p1_wins got=%h exp=%h", rd(0), exp_v); end

    set_w(0, ia(7), 32'h1234_5678, 1'b1);
    set_w(1, ia(7), 32'hDEAD_BEEF, 1'b1);
    sb.push_back(32'hDEAD_BEEF);
    tick;
    we = '0;
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL prio_swap got=%h exp=%h", rd(0), exp_v); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_x0_and_xc;
    set_w(0, ia(0), 32'hFFFF_FFFF, 1'b1);
    set_w(1, xa(3), 32'hA5A5_A5A5, 1'b1);
    tick;
    set_w(0, ia(0), 32'h0BAD_0BAD, 1'b0);
    set_w(1, ia(0), 32'hFFFF_FFFF, 1'b1);
    tick;
    we = '0;
    set_r(0, ia(0));
    set_r(1, xa(3));
    set_r(2, ia(3));
    sb.push_back(32'h0);
    sb.push_back(32'hA5A5_A5A5);
    sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL x0_zero got=%h exp=%h", rd(0), exp_v); end
    exp_v = sb.pop_front();
    n_cmp++; if (rd(1) !== exp_v) begin n_err++; $display("FAIL xc3_readback got=%h exp=%h", rd(1), exp_v); end
    exp_v = sb.pop_front();
    n_cmp++; if (rd(2) !== exp_v) begin n_err++; $display("FAIL x3_untouched got=%h exp=%h", rd(2), exp_v); end
    // Index bit 4 lies above the XC index range, so this address aliases XC3.
    set_r(0, xa(3 + 16));
    sb.push_back(32'hA5A5_A5A5);
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL xc3_alias got=%h exp=%h", rd(0), exp_v); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_bypass;
    set_w(0, ia(9), 32'h0000_0011, 1'b1);
    set_w(1, ia(9), 32'h0000_0055, 1'b1);
    set_r(0, ia(9));
    set_r(1, ia(0));
`ifdef RF_WRITE_BYPASS_EN
    sb.push_back(32'h0000_0055);
`else
    sb.push_back(32'h0);
`endif
    sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL bypass_x9 got=%h exp=%h", rd(0), exp_v); end
    exp_v = sb.pop_front();
    n_cmp++; if (rd(1) !== exp_v) begin n_err++; $display("FAIL bypass_x0 got=%h exp=%h", rd(1), exp_v); end
    sb.push_back(32'h0000_0055);
    tick;
    we = '0;
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL next_cycle_x9 got=%h exp=%h", rd(0), exp_v); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random;
    logic [AW-1:0] a0, a1, ra;
    logic [DW-1:0] d0, d1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) int_m[i] = '0;
    for (int i = 0; i < 16; i++) xc_m[i] = '0;
    for (int it = 0; it < 40; it++) begin
      a0 = AW'($urandom_range(0, 63));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 63));
      d0 = $urandom();
      d1 = $urandom();
      set_w(0, a0, d0, 1'($urandom_range(0, 1)));
      set_w(1, a1, d1, 1'($urandom_range(0, 1)));
      for (int p = 0; p < NW; p++) begin
        if (we[p]) begin
          if (waddr[p*AW + AW - 1] == 1'b0) begin
            if (waddr[p*AW +: 5] != 5'd0) int_m[waddr[p*AW +: 5]] = wdata[p*DW +: DW];
          end else begin
            xc_m[waddr[p*AW +: 4]] = wdata[p*DW +: DW];
          end
        end
      end
      tick;
      we = '0;
      for (int r = 0; r < NR; r++) begin
        ra = (r == 0) ? a0 : (r == 1) ? a1 : AW'($urandom_range(0, 63));
        set_r(r, ra);
        sb.push_back(ra[AW-1] ? xc_m[ra[3:0]] : int_m[ra[4:0]]);
      end
      #1;
      for (int r = 0; r < NR; r++) begin
        exp_v = sb.pop_front();
        n_cmp++;
        if (rd(r) !== exp_v) begin
          n_err++;
          $display("FAIL random_read it=%0d port=%0d addr=%h got=%h exp=%h",
                   it, r, raddr[r*AW +: AW], rd(r), exp_v);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_xc_clear;
    int busy_cnt, done_cnt, done_at;
    for (int i = 0; i < 16; i += 2) begin
      set_w(0, xa(i),     32'h1000_0001 + i * 32'h0101, 1'b1);
      set_w(1, xa(i + 1), 32'h1000_0001 + (i + 1) * 32'h0101, 1'b1);
      tick;
    end
    we = '0;
    set_r(0, xa(0));
    set_r(1, xa(15));
    sb.push_back(32'h1000_0001);
    sb.push_back(32'h1000_0001 + 15 * 32'h0101);
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL fill_xc0 got=%h exp=%h", rd(0), exp_v); end
    exp_v = sb.pop_front();
    n_cmp++; if (rd(1) !== exp_v) begin n_err++; $display("FAIL fill_xc15 got=%h exp=%h", rd(1), exp_v); end

    xc_init_req = 1'b1;
    tick;
    xc_init_req = 1'b0;
    // First CLEAR cycle: the XC write must be dropped, the integer write kept.
    set_w(0, xa(15), 32'h0000_0001, 1'b1);
    set_w(1, ia(10), 32'h0000_CAFE, 1'b1);
    set_r(0, xa(15));
    sb.push_back(32'h0);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        exp_v = sb.pop_front();
        n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL busy_masks_xc got=%h exp=%h", rd(0), exp_v); end
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = c; end
      tick;
      if (c == 0) we = '0;
    end
    n_cmp++; if (busy_cnt !== 4) begin n_err++; $display("FAIL clear_busy_cycles got=%0d exp=4", busy_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL clear_done_pulses got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_at !== 4) begin n_err++; $display("FAIL clear_done_cycle got=%0d exp=4", done_at); end
    for (int i = 0; i < 16; i++) begin
      set_r(0, xa(i));
      sb.push_back(32'h0);
      #1;
      exp_v = sb.pop_front();
      n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL cleared_xc%0d got=%h exp=%h", i, rd(0), exp_v); end
    end
    set_r(0, ia(10));
    sb.push_back(32'h0000_CAFE);
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL int_write_during_clear got=%h exp=%h", rd(0), exp_v); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_hold_req;
    int busy_cnt, done_cnt;
    bit seen;
    xc_init_req = 1'b1;
    tick;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      tick;
    end
    n_cmp++; if (busy_cnt !== 4) begin n_err++; $display("FAIL hold_busy_cycles got=%0d exp=4", busy_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL hold_done_pulses got=%0d exp=1", done_cnt); end

    set_w(0, xa(5), 32'h0000_0099, 1'b1);
    tick;
    we = '0;
    set_r(0, xa(5));
    sb.push_back(32'h0000_0099);
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL wait_low_xc_write got=%h exp=%h", rd(0), exp_v); end

    xc_init_req = 1'b0;
    tick;
    tick;
    xc_init_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rearm_busy got=%b exp=1", seen); end
    xc_init_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rearm_done got=%b exp=1", seen); end
    tick;
    tick;
    sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL rearm_cleared_xc5 got=%h exp=%h", rd(0), exp_v); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_clear;
    int pulses, busy_seen;
    set_w(0, ia(4),  32'h0000_0044, 1'b1);
    set_w(1, xa(14), 32'h0000_005A, 1'b1);
    tick;
    we = '0;
    set_r(0, ia(4));
    set_r(1, xa(14));
    sb.push_back(32'h0000_0044);
    sb.push_back(32'h0000_005A);
    #1;
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL pre_rst_x4 got=%h exp=%h", rd(0), exp_v); end
    exp_v = sb.pop_front();
    n_cmp++; if (rd(1) !== exp_v) begin n_err++; $display("FAIL pre_rst_xc14 got=%h exp=%h", rd(1), exp_v); end

    xc_init_req = 1'b1;
    tick;
    xc_init_req = 1'b0;
    tick;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_cycle2_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    exp_v = sb.pop_front();
    n_cmp++; if (rd(0) !== exp_v) begin n_err++; $display("FAIL rst_mid_x4 got=%h exp=%h", rd(0), exp_v); end
    exp_v = sb.pop_front();
    n_cmp++; if (rd(1) !== exp_v) begin n_err++; $display("FAIL rst_mid_xc14 got=%h exp=%h", rd(1), exp_v); end
    pulses = 0; busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rst_mid_no_done got=%0d exp=0", pulses); end
    n_cmp++; if (busy_seen !== 0) begin n_err++; $display("FAIL rst_mid_stays_idle got=%0d exp=0", busy_seen); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_write_priority();
    test_x0_and_xc();
    test_bypass();
    test_random();
    test_xc_clear();
    test_hold_req();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
